// File: rtl/switch_ctrl_rep_if.sv
// Switch-controller bus: raw keys and mode selects in, debounced key events out.
interface switch_ctrl_rep_if #(
   parameter int CH_NUM = 4
);
   logic                  CE;
   logic [CH_NUM-1:0]     S_IN;
   logic [2*CH_NUM-1:0]   MODE;
   logic [CH_NUM-1:0]     KEY_EN;
   logic [CH_NUM-1:0]     KEY_UP;
   logic [CH_NUM-1:0]     KEY_TGL;

   modport master (output CE, S_IN, MODE, input KEY_EN, KEY_UP, KEY_TGL);
   modport slave  (input CE, S_IN, MODE, output KEY_EN, KEY_UP, KEY_TGL);
endinterface

// File: rtl/switch_ctrl_rep.sv
// Multi-channel shift-register key debouncer with a shared sample prescaler,
// per-channel toggle state and single / auto-repeat / delayed auto-repeat events.
module switch_ctrl_rep #(
   parameter int CH_NUM         = 4,
   parameter int BITS_NUM       = 4,
   parameter int PRESC_BITS_NUM = 7,
   parameter int PRESC_MODULO   = 100,
   parameter int REP_BITS_NUM   = 6,
   parameter int REPEAT_DELAY   = 10,
   parameter int REPEAT_PERIOD  = 3
) (
   input  logic               CLK,
   input  logic               CLR_N,
   switch_ctrl_rep_if.slave   bus
);
   typedef enum logic [1:0] {
      MD_SINGLE = 2'b00,
      MD_REPEAT = 2'b01,
      MD_DELAY  = 2'b10
   } mode_t;

   localparam logic [PRESC_BITS_NUM-1:0] LP_PRESC_RLD = PRESC_BITS_NUM'(PRESC_MODULO - 1);
   localparam logic [PRESC_BITS_NUM-1:0] LP_PRESC_ONE = PRESC_BITS_NUM'(1);
   localparam logic [REP_BITS_NUM-1:0]   LP_REP_PER   = REP_BITS_NUM'(REPEAT_PERIOD - 1);
   localparam logic [REP_BITS_NUM-1:0]   LP_REP_DLY   = REP_BITS_NUM'(REPEAT_DELAY - 1);
   localparam logic [REP_BITS_NUM-1:0]   LP_REP_ONE   = REP_BITS_NUM'(1);

   logic [PRESC_BITS_NUM-1:0] r_presc;
   logic                      w_tick;
   logic [CH_NUM-1:0]         w_en;
   logic [CH_NUM-1:0]         w_up;
   logic [CH_NUM-1:0]         w_tgl;

   assign w_tick = bus.CE & (r_presc == '0);

   always_ff @(posedge CLK) begin
      if (!CLR_N)
         r_presc <= LP_PRESC_RLD;
      else if (bus.CE) begin
         if (w_tick)
            r_presc <= LP_PRESC_RLD;
         else
            r_presc <= r_presc - LP_PRESC_ONE;
      end
   end

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      logic [BITS_NUM-1:0]     r_sr;
      logic                    r_en;
      logic                    r_up;
      logic                    r_tgl;
      mode_t                   r_mode;
      logic [REP_BITS_NUM-1:0] r_rep;
      logic [BITS_NUM-1:0]     w_sr_nxt;
      logic                    w_press;
      logic                    w_release;
      mode_t                   w_mode_in;

      assign w_sr_nxt  = {r_sr[BITS_NUM-2:0], bus.S_IN[i]};
      assign w_press   = (&w_sr_nxt) & ~r_en;
      assign w_release = ~(|w_sr_nxt) & r_en;

      // Code 11 is folded into single-pulse mode before it is latched.
      always_comb begin
         w_mode_in = MD_SINGLE;
         case (bus.MODE[2*i +: 2])
            2'b01:   w_mode_in = MD_REPEAT;
            2'b10:   w_mode_in = MD_DELAY;
            default: w_mode_in = MD_SINGLE;
         endcase
      end

      always_ff @(posedge CLK) begin
         if (!CLR_N) begin
            r_sr   <= '0;
            r_en   <= 1'b0;
            r_up   <= 1'b0;
            r_tgl  <= 1'b0;
            r_mode <= MD_SINGLE;
            r_rep  <= '0;
         end else begin
            r_up <= 1'b0;
            if (w_tick) begin
               r_sr <= w_sr_nxt;
               if (w_press) begin
                  r_en   <= 1'b1;
                  r_tgl  <= ~r_tgl;
                  r_up   <= 1'b1;
                  r_mode <= w_mode_in;
                  r_rep  <= (w_mode_in == MD_DELAY) ? LP_REP_DLY : LP_REP_PER;
               end else if (w_release) begin
                  r_en  <= 1'b0;
                  r_rep <= '0;
               end else if (r_en && (r_mode != MD_SINGLE)) begin
                  // Repeats keep firing while a release is still being qualified.
                  if (r_rep == '0) begin
                     r_up  <= 1'b1;
                     r_rep <= LP_REP_PER;
                  end else begin
                     r_rep <= r_rep - LP_REP_ONE;
                  end
               end
            end
         end
      end

      assign w_en[i]  = r_en;
      assign w_up[i]  = r_up;
      assign w_tgl[i] = r_tgl;
   end

   assign bus.KEY_EN  = w_en;
   assign bus.KEY_UP  = w_up;
   assign bus.KEY_TGL = w_tgl;
endmodule

// File: tb/tb_switch_ctrl_rep.sv
// Tick-stepped vector bench for switch_ctrl_rep: two channels, sample tick every 4 clocks.
module tb_switch_ctrl_rep;
   logic CLK = 1'b0;
   logic CLR_N = 1'b0;
   always #5 CLK = ~CLK;

   switch_ctrl_rep_if #(.CH_NUM(2)) bus ();

   switch_ctrl_rep #(
      .CH_NUM(2), .BITS_NUM(4), .PRESC_BITS_NUM(7), .PRESC_MODULO(4),
      .REP_BITS_NUM(6), .REPEAT_DELAY(5), .REPEAT_PERIOD(2)
   ) dut (
      .CLK(CLK), .CLR_N(CLR_N), .bus(bus)
   );

   typedef struct packed {
      logic [1:0] s;
      logic [3:0] m;
      logic [1:0] en;
      logic [1:0] up;
      logic [1:0] tgl;
   } vec_t;

   typedef struct packed {
      logic [1:0] en;
      logic [1:0] up;
      logic [1:0] tgl;
   } exp_t;

   vec_t tv[$];
   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   rst_at;

   function automatic void add(input int n, input logic [1:0] s, input logic [3:0] m,
                               input logic [1:0] en, input logic [1:0] up, input logic [1:0] tgl);
      for (int k = 0; k < n; k++) tv.push_back('{s, m, en, up, tgl});
   endfunction

   task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got en/up/tgl=%b expected %b", nm, act, exp);
      else
         passed++;
   endtask

   // One sample period: drive, then the 4th edge is the tick edge.
   task automatic step(input vec_t v, input int idx);
      exp_t e;
      logic stray;
      bus.S_IN = v.s;
      bus.MODE = v.m;
      sb.push_back('{v.en, v.up, v.tgl});
      stray = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge CLK);
         #1;
         if (k < 4 && bus.KEY_UP !== 2'b00) stray = 1'b1;
      end
      chk($sformatf("up_between_ticks%0d", idx), {5'b0, stray}, 6'b0);
      if (sb.size() == 0) begin
         chk($sformatf("scoreboard_empty%0d", idx), 6'h3f, 6'h00);
      end else begin
         e = sb.pop_front();
         chk($sformatf("tick%0d", idx), {bus.KEY_EN, bus.KEY_UP, bus.KEY_TGL}, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: still running, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // idle after reset
      add(2, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
      // clean press / release / second press, ch0 single
      add(3, 2'b01, 4'b0000, 2'b00, 2'b00, 2'b00);
      add(1, 2'b01, 4'b0000, 2'b01, 2'b01, 2'b01);
      add(1, 2'b01, 4'b0000, 2'b01, 2'b00, 2'b01);
      add(3, 2'b00, 4'b0000, 2'b01, 2'b00, 2'b01);
      add(1, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b01);
      add(3, 2'b01, 4'b0000, 2'b00, 2'b00, 2'b01);
      add(1, 2'b01, 4'b0000, 2'b01, 2'b01, 2'b00);
      add(3, 2'b00, 4'b0000, 2'b01, 2'b00, 2'b00);
      add(1, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
      // bounce 1,0,1,1,1,1 then a single-0 glitch while held
      add(1, 2'b01, 4'b0000, 2'b00, 2'b00, 2'b00);
      add(1, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
      add(3, 2'b01, 4'b0000, 2'b00, 2'b00, 2'b00);
      add(1, 2'b01, 4'b0000, 2'b01, 2'b01, 2'b01);
      add(1, 2'b00, 4'b0000, 2'b01, 2'b00, 2'b01);
      add(2, 2'b01, 4'b0000, 2'b01, 2'b00, 2'b01);
      add(3, 2'b00, 4'b0000, 2'b01, 2'b00, 2'b01);
      add(1, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b01);
      // ch1 auto-repeat: pulses at P, P+2 .. P+10, and P+12 while release qualifies
      add(3, 2'b10, 4'b0100, 2'b00, 2'b00, 2'b01);
      add(1, 2'b10, 4'b0100, 2'b10, 2'b10, 2'b11);
      for (int j = 1; j <= 10; j++)
         add(1, 2'b10, 4'b0100, 2'b10, (j % 2 == 0) ? 2'b10 : 2'b00, 2'b11);
      add(1, 2'b00, 4'b0100, 2'b10, 2'b00, 2'b11);
      add(1, 2'b00, 4'b0100, 2'b10, 2'b10, 2'b11);
      add(1, 2'b00, 4'b0100, 2'b10, 2'b00, 2'b11);
      add(1, 2'b00, 4'b0100, 2'b00, 2'b00, 2'b11);
      // ch0 delayed repeat: pulses at P, P+5; release lands at P+6, nothing after
      add(3, 2'b01, 4'b0010, 2'b00, 2'b00, 2'b11);
      add(1, 2'b01, 4'b0010, 2'b01, 2'b01, 2'b10);
      add(2, 2'b01, 4'b0010, 2'b01, 2'b00, 2'b10);
      add(2, 2'b00, 4'b0010, 2'b01, 2'b00, 2'b10);
      add(1, 2'b00, 4'b0010, 2'b01, 2'b01, 2'b10);
      add(4, 2'b00, 4'b0010, 2'b00, 2'b00, 2'b10);
      // both channels together (ch1 code 11 acts as single), reset mid-hold
      add(3, 2'b11, 4'b1101, 2'b00, 2'b00, 2'b10);
      add(1, 2'b11, 4'b1101, 2'b11, 2'b11, 2'b01);
      add(1, 2'b11, 4'b1101, 2'b11, 2'b00, 2'b01);
      rst_at = tv.size();
      // re-qualify after reset, then MODE swap mid-hold must not matter
      add(3, 2'b11, 4'b1101, 2'b00, 2'b00, 2'b00);
      add(1, 2'b11, 4'b1101, 2'b11, 2'b11, 2'b11);
      add(1, 2'b11, 4'b0100, 2'b11, 2'b00, 2'b11);
      add(1, 2'b11, 4'b0100, 2'b11, 2'b01, 2'b11);
      add(1, 2'b11, 4'b0100, 2'b11, 2'b00, 2'b11);
      add(1, 2'b11, 4'b0100, 2'b11, 2'b01, 2'b11);

      bus.CE = 1'b1;
      bus.S_IN = 2'b00;
      bus.MODE = 4'b0000;
      CLR_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_state", {bus.KEY_EN, bus.KEY_UP, bus.KEY_TGL}, 6'b0);
      CLR_N = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         if (i == rst_at) begin
            CLR_N = 1'b0;
            @(posedge CLK);
            #1;
            chk("mid_hold_reset", {bus.KEY_EN, bus.KEY_UP, bus.KEY_TGL}, 6'b0);
            CLR_N = 1'b1;
         end
         step(tv[i], i);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/switch_ctrl_rep.md
Name: switch_ctrl_rep

Overview:
- Multi-channel key debouncer. It generalises the single-channel shift-register switch controller.
- Adds per-channel toggle output and three repetition modes: single pulse, auto-repeat, and auto-repeat after an initial delay.
- Sits between raw board push-buttons and the countdown-timer control FSM.
- Uses one shared internal prescaler, so every channel samples on the same slow tick.

Parameters:
- CH_NUM, 4, number of independent switch channels.
- BITS_NUM, 4, debounce shift-register length per channel (>=2).
- PRESC_BITS_NUM, 7, prescaler counter width.
- PRESC_MODULO, 100, CE cycles per sample tick (>=1, <=2^PRESC_BITS_NUM).
- REP_BITS_NUM, 6, repeat counter width.
- REPEAT_DELAY, 10, ticks from press to first repeat pulse in mode 2 (>=1).
- REPEAT_PERIOD, 3, ticks between repeat pulses in modes 1/2 (>=1).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- CLR_N  in  1  synchronous active-low reset.
- CE  in  1  clock enable feeding the prescaler.
- S_IN  in  CH_NUM  raw switch inputs, active high, assumed already synchronised.
- MODE  in  2*CH_NUM  per-channel mode, bits [2i+1:2i]: 00 single, 01 repeat, 10 repeat-after-delay, 11 = treated as 00.
- KEY_EN  out  CH_NUM  debounced level (pressed).
- KEY_UP  out  CH_NUM  one-CLK event pulse (press or repeat).
- KEY_TGL  out  CH_NUM  toggled state, flips on each press event.

Behaviour:
- Reset: CLR_N low at a CLK edge clears everything. This covers the prescaler (loads PRESC_MODULO-1), all shift registers, KEY_EN, KEY_UP, KEY_TGL, repeat counters and latched modes. Reset mid-hold drops KEY_EN at once; a still-held key must re-qualify through BITS_NUM ticks.
- Prescaler: down-counter, decrements only when CE=1. TICK = CE & (cnt==0); on TICK it reloads PRESC_MODULO-1. With CE held at 1, the first TICK occurs in the PRESC_MODULO-th cycle after reset release, then every PRESC_MODULO cycles. CE=0 freezes the prescaler; no ticks are produced.
- Sampling: on TICK each channel shifts SR <= {SR[BITS_NUM-2:0], S_IN[i]}. Nothing else updates between ticks.
- Press event: at a TICK where the next SR is all ones and KEY_EN[i]=0.
  - KEY_EN[i] <= 1.
  - KEY_TGL[i] flips.
  - The channel's MODE field is latched.
  - KEY_UP[i] <= 1 for exactly one CLK (the cycle following the TICK edge).
- Release event: at a TICK where the next SR is all zeros and KEY_EN[i]=1.
  - KEY_EN[i] <= 0; the repeat counter is cleared; no pulse is emitted.
  - Mixed patterns hold KEY_EN unchanged (hysteresis).
- Repeat counter, per channel, REP_BITS_NUM wide:
  - On a press event it loads REPEAT_PERIOD-1 (latched mode 01) or REPEAT_DELAY-1 (mode 10). It is unused in mode 00.
  - On each later TICK with KEY_EN=1 in mode 01/10: if cnt==0, emit a KEY_UP pulse (one CLK after the TICK) and reload REPEAT_PERIOD-1; else decrement.
  - Resulting timing: first repeat REPEAT_PERIOD ticks after the press (mode 01) or REPEAT_DELAY ticks after it (mode 10); then every REPEAT_PERIOD ticks.
- KEY_UP is a registered output, cleared every CLK in which no event occurs. Press and repeat can never coincide, since repeat requires KEY_EN already 1.
- A MODE change while a key is held has no effect until the next press event.
- A TICK coinciding with reset: reset wins.
- Channels are fully independent. Any number of channels may pulse on the same cycle.

Test Plan:
Bench parameters: CH_NUM=2, BITS_NUM=4, PRESC_MODULO=4, REPEAT_DELAY=5, REPEAT_PERIOD=2, CE=1.
1. Reset then idle, S_IN=00 -> all outputs 0; TICK first at cycle 4 after release, then every 4 cycles.
2. Clean press, ch0 mode 00, S_IN[0] high from before tick 1 -> press event at tick 4; KEY_EN[0]=1; KEY_UP[0] high one CLK after tick 4 only; KEY_TGL[0]=1. Release -> KEY_EN[0]=0 at the 4th tick of low samples; a second press gives KEY_TGL[0]=0.
3. Bounce, pattern 1,0,1,1,1,1 on ticks -> no event until all-ones at tick 6; a single 0 glitch while pressed does not drop KEY_EN.
4. Mode 01, held 10 ticks after press -> KEY_UP pulses at press tick P, P+2, P+4, P+6, P+8, P+10.
5. Mode 10, held -> pulses at P, P+5, P+7, P+9; a release at P+6 gives no further pulses, with counter cleared.
6. Both channels pressed on the same tick, then CLR_N low for one CLK mid-hold -> both pulse on the same cycle; after reset all outputs 0; re-press requires 4 ticks; MODE change mid-hold is ignored.
